// File: rtl/vga_draw_arbiter.sv
// -----------------------------------------------------------------------------
// vga_draw_arbiter
//
// Shares the VGA adapter's single pixel-write port between NUM_CH sprite/object
// drawers (channel 0 = player). A drawer holds req high for its whole burst and
// owns the port while grant is set for it. Each pixel is handed over with a
// one-cycle ack/plot pair. Consecutive plots are spaced by a global pace
// counter that freezes while the adapter reports busy.
//
// Build option:
//   VGA_DRAW_ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration, search
//                                            starts at the channel after the
//                                            last owner
//                                undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk        system clock, rising-edge active
//   resetn     asynchronous active-low reset
//   req        per-channel burst request
//   x_in       packed x coordinates, channel i at [i*X_W +: X_W]
//   y_in       packed y coordinates, same packing
//   color_in   packed colours, same packing
//   vga_busy   adapter cannot take a pixel this cycle
//   grant      one-hot (or zero) current owner
//   ack        one-cycle pulse to the owner when its pixel is taken
//   x_out      registered pixel x, held between plots
//   y_out      registered pixel y, held between plots
//   color_out  registered pixel colour, held between plots
//   plot       one-cycle write strobe to the adapter
// -----------------------------------------------------------------------------
module vga_draw_arbiter #(
   parameter int NUM_CH      = 4,
   parameter int X_W         = 8,
   parameter int Y_W         = 7,
   parameter int C_W         = 3,
   parameter int PACE_CYCLES = 100
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [NUM_CH-1:0]       req,
   input  logic [NUM_CH*X_W-1:0]   x_in,
   input  logic [NUM_CH*Y_W-1:0]   y_in,
   input  logic [NUM_CH*C_W-1:0]   color_in,
   input  logic                    vga_busy,
   output logic [NUM_CH-1:0]       grant,
   output logic [NUM_CH-1:0]       ack,
   output logic [X_W-1:0]          x_out,
   output logic [Y_W-1:0]          y_out,
   output logic [C_W-1:0]          color_out,
   output logic                    plot
);

   localparam int OW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PW = $clog2(PACE_CYCLES + 1);
   localparam logic [PW-1:0] PACE_LOAD = PW'(PACE_CYCLES - 1);

   typedef enum logic {
      S_IDLE,
      S_OWN
   } state_t;

   state_t            state_q, state_d;
   logic [OW-1:0]     owner_q, owner_d;
   logic [PW-1:0]     pace_q,  pace_d;
   logic [NUM_CH-1:0] grant_d, ack_d;
   logic [X_W-1:0]    x_d;
   logic [Y_W-1:0]    y_d;
   logic [C_W-1:0]    color_d;
   logic              plot_d;

   logic              win_valid;
   logic [OW-1:0]     win_idx;
   logic              accept;
   logic [X_W-1:0]    own_x;
   logic [Y_W-1:0]    own_y;
   logic [C_W-1:0]    own_color;

`ifdef VGA_DRAW_ARB_ROUND_ROBIN_EN
   logic [OW-1:0]     rr_q, rr_d;
`endif

   // Only the owner's pixel data is ever looked at.
   assign own_x     = x_in[int'(owner_q) * X_W +: X_W];
   assign own_y     = y_in[int'(owner_q) * Y_W +: Y_W];
   assign own_color = color_in[int'(owner_q) * C_W +: C_W];

   assign accept = (state_q == S_OWN) && req[owner_q] && !vga_busy && (pace_q == '0);

   // Winner search. Round-robin starts at rr_q and wraps; fixed priority
   // starts at channel 0.
   always_comb begin : arb_sel
      int unsigned idx;
      win_valid = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
`ifdef VGA_DRAW_ARB_ROUND_ROBIN_EN
         idx = (32'(rr_q) + k) % NUM_CH;
`else
         idx = k;
`endif
         if (!win_valid && req[idx]) begin
            win_valid = 1'b1;
            win_idx   = OW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      grant_d = grant;
      ack_d   = '0;
      plot_d  = 1'b0;
      x_d     = x_out;
      y_d     = y_out;
      color_d = color_out;
`ifdef VGA_DRAW_ARB_ROUND_ROBIN_EN
      rr_d    = rr_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (win_valid) begin
               state_d          = S_OWN;
               owner_d          = win_idx;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
            end
         end
         S_OWN: begin
            if (!req[owner_q]) begin
               state_d = S_IDLE;
               grant_d = '0;
`ifdef VGA_DRAW_ARB_ROUND_ROBIN_EN
               rr_d = (owner_q == OW'(NUM_CH - 1)) ? '0 : owner_q + 1'b1;
`endif
            end else if (accept) begin
               plot_d  = 1'b1;
               ack_d   = grant;
               x_d     = own_x;
               y_d     = own_y;
               color_d = own_color;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase

      // Pacing is global: it keeps running across grant changes and in IDLE.
      if (accept) begin
         pace_d = PACE_LOAD;
      end else if ((pace_q != '0) && !vga_busy) begin
         pace_d = pace_q - 1'b1;
      end else begin
         pace_d = pace_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         owner_q   <= '0;
         pace_q    <= '0;
         grant     <= '0;
         ack       <= '0;
         plot      <= 1'b0;
         x_out     <= '0;
         y_out     <= '0;
         color_out <= '0;
`ifdef VGA_DRAW_ARB_ROUND_ROBIN_EN
         rr_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         pace_q    <= pace_d;
         grant     <= grant_d;
         ack       <= ack_d;
         plot      <= plot_d;
         x_out     <= x_d;
         y_out     <= y_d;
         color_out <= color_d;
`ifdef VGA_DRAW_ARB_ROUND_ROBIN_EN
         rr_q      <= rr_d;
`endif
      end
   end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_draw_arbiter
//
// Drives vga_draw_arbiter (NUM_CH=4, PACE_CYCLES=4) with directed scenarios
// followed by randomized drawer traffic. Expected outputs come from a
// transaction-level model: owner selection by rule, pixel pacing expressed as
// "non-stalled cycles elapsed since the last plot".
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_vga_draw_arbiter;

   localparam int N    = 4;
   localparam int XW   = 8;
   localparam int YW   = 7;
   localparam int CW   = 3;
   localparam int PACE = 4;

   logic            clk = 1'b0;
   logic            resetn;
   logic [N-1:0]    req;
   logic [N*XW-1:0] x_in;
   logic [N*YW-1:0] y_in;
   logic [N*CW-1:0] color_in;
   logic            vga_busy;
   logic [N-1:0]    grant;
   logic [N-1:0]    ack;
   logic [XW-1:0]   x_out;
   logic [YW-1:0]   y_out;
   logic [CW-1:0]   color_out;
   logic            plot;

   vga_draw_arbiter #(
      .NUM_CH      (N),
      .X_W         (XW),
      .Y_W         (YW),
      .C_W         (CW),
      .PACE_CYCLES (PACE)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req       (req),
      .x_in      (x_in),
      .y_in      (y_in),
      .color_in  (color_in),
      .vga_busy  (vga_busy),
      .grant     (grant),
      .ack       (ack),
      .x_out     (x_out),
      .y_out     (y_out),
      .color_out (color_out),
      .plot      (plot)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int            m_owner;
   int            m_ptr;
   int            m_since;   // non-stalled cycles elapsed since last plot
   int            m_plots;
   logic [N-1:0]  m_ack;
   logic          m_plot;
   logic [XW-1:0] m_x;
   logic [YW-1:0] m_y;
   logic [CW-1:0] m_c;

   // drawer stimulus state
   logic [N-1:0]  req_r;
   int            rem [N];
   int            bursts_left [N];
   logic [XW-1:0] cx [N];
   logic [YW-1:0] cy [N];
   logic [CW-1:0] cc [N];
   int            mode;       // 0 quiet, 1 directed bursts, 2 random traffic
   int            fixed_len;
   int            stall_cnt;
   bit            stall_en;
   int            cyc;

   // observation logs
   int            plot_cyc [$];
   int            grant_order [$];
   int            grant_cyc;
   logic [N-1:0]  prev_grant;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic int pick_winner(input logic [N-1:0] r, input int start);
      for (int k = 0; k < N; k++) begin
         if (r[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_since = PACE;
      m_ack   = '0;
      m_plot  = 1'b0;
      m_x     = '0;
      m_y     = '0;
      m_c     = '0;
   endtask

   // One rising edge of the arbiter, evaluated on the inputs currently driven.
   task automatic model_edge();
      int w;
      int start;
      bit plotted;
      plotted = 1'b0;
      m_ack   = '0;
      m_plot  = 1'b0;
`ifdef VGA_DRAW_ARB_ROUND_ROBIN_EN
      start = m_ptr;
`else
      start = 0;
`endif
      if (m_owner < 0) begin
         w = pick_winner(req, start);
         if (w >= 0) m_owner = w;
      end else if (!req[m_owner]) begin
         m_ptr   = (m_owner + 1) % N;
         m_owner = -1;
      end else if (!vga_busy && m_since >= PACE - 1) begin
         m_plot         = 1'b1;
         m_ack[m_owner] = 1'b1;
         m_x            = x_in[m_owner*XW +: XW];
         m_y            = y_in[m_owner*YW +: YW];
         m_c            = color_in[m_owner*CW +: CW];
         m_since        = 0;
         m_plots++;
         plotted        = 1'b1;
      end
      if (!plotted && !vga_busy && m_since < PACE) m_since++;
   endtask

   task automatic check_outputs();
      logic [N-1:0] eg;
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      check("grant", 32'(grant), 32'(eg));
      check("ack", 32'(ack), 32'(m_ack));
      check("plot", 32'(plot), 32'(m_plot));
      check("x_out", 32'(x_out), 32'(m_x));
      check("y_out", 32'(y_out), 32'(m_y));
      check("color_out", 32'(color_out), 32'(m_c));
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (m_owner == i) begin
            if (m_ack[i] && rem[i] > 0) rem[i]--;
            if (rem[i] == 0 && req_r[i]) begin
               req_r[i] = 1'b0;
               if (bursts_left[i] > 0) bursts_left[i]--;
            end
         end else if (!req_r[i]) begin
            if ((mode == 1 && bursts_left[i] > 0) ||
                (mode == 2 && $urandom_range(0, 3) == 0)) begin
               req_r[i] = 1'b1;
               rem[i]   = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
            end
         end else if (mode == 2 && $urandom_range(0, 7) == 0) begin
            req_r[i] = 1'b0;
         end
      end
      req = req_r;
      for (int i = 0; i < N; i++) begin
         if (mode == 2) begin
            x_in[i*XW +: XW]     = XW'($urandom);
            y_in[i*YW +: YW]     = YW'($urandom);
            color_in[i*CW +: CW] = CW'($urandom);
         end else begin
            x_in[i*XW +: XW]     = cx[i];
            y_in[i*YW +: YW]     = cy[i];
            color_in[i*CW +: CW] = cc[i];
         end
      end
      if (stall_en && m_plot && m_plots == 3) stall_cnt = 6;
      if (mode == 2) begin
         vga_busy = ($urandom_range(0, 3) == 0);
      end else if (stall_cnt > 0) begin
         vga_busy = 1'b1;
         stall_cnt--;
      end else begin
         vga_busy = 1'b0;
      end
   endtask

   // Called on a falling edge: check, log, drive, advance model, wait.
   task automatic step();
      check_outputs();
      if (plot === 1'b1) plot_cyc.push_back(cyc);
      if (prev_grant == '0 && grant != '0) begin
         grant_cyc = cyc;
         for (int i = 0; i < N; i++) if (grant[i]) grant_order.push_back(i);
      end
      prev_grant = grant;
      drive();
      if (resetn) model_edge();
      @(negedge clk);
      cyc++;
   endtask

   task automatic clear_drivers();
      req_r     = '0;
      req       = '0;
      vga_busy  = 1'b0;
      stall_cnt = 0;
      stall_en  = 1'b0;
      for (int i = 0; i < N; i++) begin
         rem[i]         = 0;
         bursts_left[i] = 0;
      end
      prev_grant = '0;
   endtask

   task automatic reset_dut();
      resetn = 1'b0;
      clear_drivers();
      model_reset();
      @(negedge clk);
      cyc++;
      resetn = 1'b1;
   endtask

   initial begin
      int exp_order [4];
      resetn   = 1'b1;
      x_in     = '0;
      y_in     = '0;
      color_in = '0;
      cyc      = 0;
      mode     = 0;
      fixed_len = 0;
      m_plots  = 0;
      clear_drivers();
      for (int i = 0; i < N; i++) begin
         cx[i] = XW'($urandom);
         cy[i] = YW'($urandom);
         cc[i] = CW'($urandom);
      end
      #2;
      reset_dut();

      // reset and idle
      repeat (20) step();

      // pacing with a mid-pace stall on channel 1
      mode      = 1;
      fixed_len = 5;
      bursts_left[1] = 1;
      cx[1] = 8'd10;
      cy[1] = 7'd5;
      cc[1] = 3'd3;
      stall_en = 1'b1;
      m_plots  = 0;
      plot_cyc.delete();
      grant_order.delete();
      repeat (50) step();
      check("pace_plot_count", 32'(plot_cyc.size()), 32'd5);
      check("pace_grant_ch", 32'(grant_order.size() > 0 ? grant_order[0] : -1), 32'd1);
      if (plot_cyc.size() == 5) begin
         check("first_plot_latency", 32'(plot_cyc[0] - grant_cyc), 32'd1);
         check("gap1", 32'(plot_cyc[1] - plot_cyc[0]), 32'(PACE));
         check("gap2", 32'(plot_cyc[2] - plot_cyc[1]), 32'(PACE));
         check("gap_stalled", 32'(plot_cyc[3] - plot_cyc[2]), 32'(PACE + 6));
         check("gap4", 32'(plot_cyc[4] - plot_cyc[3]), 32'(PACE));
      end

      // arbitration order with req=1011, two-pixel bursts
      reset_dut();
      stall_en  = 1'b0;
      fixed_len = 2;
      bursts_left[0] = 2;
      bursts_left[1] = 1;
      bursts_left[3] = 1;
      grant_order.delete();
      repeat (70) step();
`ifdef VGA_DRAW_ARB_ROUND_ROBIN_EN
      exp_order = '{0, 1, 3, 0};
`else
      exp_order = '{0, 0, 1, 3};
`endif
      check("arb_burst_count", 32'(grant_order.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("arb_order[%0d]", k),
               32'(k < grant_order.size() ? grant_order[k] : -1), 32'(exp_order[k]));
      end

      // randomized traffic
      mode      = 2;
      fixed_len = 0;
      repeat (1500) step();

      // asynchronous reset in the middle of a burst
      mode = 1;
      reset_dut();
      fixed_len = 4;
      bursts_left[2] = 1;
      repeat (8) step();
      check("mid_burst_grant", 32'(grant), 32'b0100);
      #2 resetn = 1'b0;
      #1;
      check("async_grant", 32'(grant), 32'd0);
      check("async_ack", 32'(ack), 32'd0);
      check("async_plot", 32'(plot), 32'd0);
      check("async_x", 32'(x_out), 32'd0);
      check("async_y", 32'(y_out), 32'd0);
      check("async_color", 32'(color_out), 32'd0);
      clear_drivers();
      model_reset();
      @(negedge clk);
      cyc++;
      resetn = 1'b1;
      mode = 2;
      repeat (300) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
